// File: rtl/axis_fsb_packetizer.sv
// Width adapter between a 32-bit AXI-Stream pair and the 80-bit FSB client node.
// RX packs beats_p beats into one FSB packet; TX splits one FSB packet into beats_p beats.
module axis_fsb_packetizer #(
  parameter int axis_width_p = 32,
  parameter int fsb_width_p  = 80,
  parameter int beats_p      = 4,
  parameter int err_cnt_w_p  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    s_axis_tvalid_i,
  output logic                    s_axis_tready_o,
  input  logic [axis_width_p-1:0] s_axis_tdata_i,
  input  logic                    s_axis_tlast_i,
  output logic                    fsb_v_o,
  output logic [fsb_width_p-1:0]  fsb_data_o,
  input  logic                    fsb_ready_i,
  input  logic                    fsb_v_i,
  input  logic [fsb_width_p-1:0]  fsb_data_i,
  output logic                    fsb_yumi_o,
  output logic                    m_axis_tvalid_o,
  input  logic                    m_axis_tready_i,
  output logic [axis_width_p-1:0] m_axis_tdata_o,
  output logic                    m_axis_tlast_o,
  output logic                    rx_err_o,
  output logic [err_cnt_w_p-1:0]  rx_err_cnt_o
);

  localparam int wide_w_lp = axis_width_p * beats_p;
  localparam int cnt_w_lp  = (beats_p > 1) ? $clog2(beats_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_p - 1);

  // ---------------- RX packing ----------------
  logic [cnt_w_lp-1:0]    r_rcnt;
  logic                   r_full;
  logic                   r_rx_err;
  logic [err_cnt_w_p-1:0] r_err_cnt;
  logic                   w_rx_hs;
  logic                   w_rx_last_beat;
  logic                   w_rx_frame_err;

  assign w_rx_hs        = s_axis_tvalid_i & ~r_full;
  assign w_rx_last_beat = (r_rcnt == last_beat_lp);
  // Early tlast and a missing tlast on the final beat are both framing errors.
  assign w_rx_frame_err = w_rx_hs & (s_axis_tlast_i ^ w_rx_last_beat);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rcnt    <= '0;
      r_full    <= 1'b0;
      r_rx_err  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_rx_hs) begin
        if (w_rx_last_beat) begin
          r_rcnt <= '0;
          r_full <= 1'b1;
        end else if (s_axis_tlast_i) begin
          r_rcnt <= '0;
        end else begin
          r_rcnt <= r_rcnt + cnt_w_lp'(1);
        end
      end else if (r_full && fsb_ready_i) begin
        r_full <= 1'b0;
      end
      r_rx_err <= w_rx_frame_err;
      if (w_rx_frame_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + err_cnt_w_p'(1);
      end
    end
  end

  // Only the lane bits that reach fsb_data_o are stored; the rest would be discarded anyway.
  for (genvar gi = 0; gi < beats_p; gi++) begin : g_rx_lane
    localparam int lo_lp = gi * axis_width_p;
    if (lo_lp < fsb_width_p) begin : g_used
      localparam int w_lp = ((fsb_width_p - lo_lp) < axis_width_p) ? (fsb_width_p - lo_lp) : axis_width_p;
      logic [w_lp-1:0] r_lane;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          r_lane <= '0;
        end else if (w_rx_hs && (r_rcnt == cnt_w_lp'(gi))) begin
          r_lane <= s_axis_tdata_i[w_lp-1:0];
        end
      end
      assign fsb_data_o[lo_lp +: w_lp] = r_lane;
    end
  end

  assign s_axis_tready_o = ~r_full;
  assign fsb_v_o         = r_full;
  assign rx_err_o        = r_rx_err;
  assign rx_err_cnt_o    = r_err_cnt;

  // ---------------- TX serialising ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t              r_tx_state;
  tx_state_t              w_tx_state_next;
  logic [fsb_width_p-1:0] r_shreg;
  logic [cnt_w_lp-1:0]    r_tcnt;
  logic                   w_tx_load;
  logic                   w_tx_adv;
  logic                   w_tx_last_beat;
  logic [wide_w_lp-1:0]   w_tx_wide;
  logic [axis_width_p-1:0] w_tx_beat [beats_p];

  assign w_tx_last_beat = (r_tcnt == last_beat_lp);

  always_comb begin
    w_tx_state_next = r_tx_state;
    fsb_yumi_o      = 1'b0;
    m_axis_tvalid_o = 1'b0;
    w_tx_load       = 1'b0;
    w_tx_adv        = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        fsb_yumi_o = fsb_v_i;
        w_tx_load  = fsb_v_i;
        if (fsb_v_i) w_tx_state_next = TX_SEND;
      end
      TX_SEND: begin
        m_axis_tvalid_o = 1'b1;
        if (m_axis_tready_i) begin
          if (w_tx_last_beat) begin
            // Reload straight from the final beat so packets stream without a bubble.
            if (fsb_v_i) begin
              fsb_yumi_o = 1'b1;
              w_tx_load  = 1'b1;
            end else begin
              w_tx_state_next = TX_IDLE;
            end
          end else begin
            w_tx_adv = 1'b1;
          end
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_tx_state <= TX_IDLE;
    else         r_tx_state <= w_tx_state_next;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_shreg <= '0;
      r_tcnt  <= '0;
    end else if (w_tx_load) begin
      r_shreg <= fsb_data_i;
      r_tcnt  <= '0;
    end else if (w_tx_adv) begin
      r_tcnt <= r_tcnt + cnt_w_lp'(1);
    end
  end

  always_comb begin
    w_tx_wide                  = '0;
    w_tx_wide[fsb_width_p-1:0] = r_shreg;
  end

  for (genvar gi = 0; gi < beats_p; gi++) begin : g_tx_beat
    assign w_tx_beat[gi] = w_tx_wide[gi*axis_width_p +: axis_width_p];
  end

  assign m_axis_tdata_o = w_tx_beat[r_tcnt];
  assign m_axis_tlast_o = (r_tx_state == TX_SEND) & w_tx_last_beat;

endmodule
